// File: rtl/key_debounce_pulse_if.sv
// Key conditioner signal bundle.
// The board side (master) drives the raw key; the conditioner (slave)
// returns the debounced level, press/release pulses, press counter and
// a debug view of its FSM state.
// o_pressed/o_released are one-cycle strobes with no back-pressure: a
// consumer samples them on any clock edge where they are high; there is
// no ready, so a strobe is never held or retried.
interface key_debounce_pulse_if;
  logic       i_key_n;
  logic       o_level;
  logic       o_pressed;
  logic       o_released;
  logic [7:0] o_press_count;
  logic [1:0] o_state;

  modport master (
    output i_key_n,
    input  o_level,
    input  o_pressed,
    input  o_released,
    input  o_press_count,
    input  o_state
  );

  modport slave (
    input  i_key_n,
    output o_level,
    output o_pressed,
    output o_released,
    output o_press_count,
    output o_state
  );
endinterface

// File: rtl/key_debounce_pulse.sv
// Pushbutton conditioner for an active-low board key.
// Two-flop synchronizer, then a four-state debounce FSM that accepts a
// level change only after the synchronized key has been stable for
// DEBOUNCE_CYCLES cycles. Emits registered one-cycle press/release
// pulses and an 8-bit wrapping press counter.
// Optional auto-repeat while held: define KEY_AUTOREPEAT_EN.
module key_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  key_debounce_pulse_if.slave   key
);

  typedef enum logic [1:0] {
    S_UP       = 2'd0,
    S_UP_CHK   = 2'd1,
    S_DOWN     = 2'd2,
    S_DOWN_CHK = 2'd3
  } state_t;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             sync1;
  logic             key_s;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             rep_phase, rep_phase_n;  // 0: waiting initial delay, 1: periodic
  logic             level, level_n;
  logic             pressed, pressed_n;
  logic             released, released_n;
  logic [7:0]       press_count, press_count_n;
  logic             repeat_hit;

  // Two-flop synchronizer for the asynchronous key; resets to "released".
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= 1'b1;
      key_s <= 1'b1;
    end else begin
      sync1 <= key.i_key_n;
      key_s <= sync1;
    end
  end

  // FSM, timing counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_UP;
      cnt         <= '0;
      rep_phase   <= 1'b0;
      level       <= 1'b0;
      pressed     <= 1'b0;
      released    <= 1'b0;
      press_count <= 8'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rep_phase   <= rep_phase_n;
      level       <= level_n;
      pressed     <= pressed_n;
      released    <= released_n;
      press_count <= press_count_n;
    end
  end

  // Saturating increment: the counter must never wrap back to a match.
  assign cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign repeat_hit = rep_phase ? (cnt == RP_LAST) : (cnt == RD_LAST);

  // Next-state, counter and pulse decode; every state entry clears the counter.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    rep_phase_n   = rep_phase;
    level_n       = level;
    pressed_n     = 1'b0;
    released_n    = 1'b0;
    press_count_n = press_count;
    case (state)
      S_UP: begin
        if (!key_s) begin
          state_n = S_UP_CHK;
          cnt_n   = '0;
        end
      end
      S_UP_CHK: begin
        if (key_s) begin
          state_n = S_UP;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n       = S_DOWN;
          cnt_n         = '0;
          rep_phase_n   = 1'b0;
          level_n       = 1'b1;
          pressed_n     = 1'b1;
          press_count_n = press_count + 8'd1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_DOWN: begin
        if (key_s) begin
          state_n     = S_DOWN_CHK;
          cnt_n       = '0;
          rep_phase_n = 1'b0;
        end else if (AUTOREPEAT) begin
          if (repeat_hit) begin
            cnt_n         = '0;
            rep_phase_n   = 1'b1;
            pressed_n     = 1'b1;
            press_count_n = press_count + 8'd1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      S_DOWN_CHK: begin
        if (!key_s) begin
          // Bounce back to held: repeat timing restarts from the initial delay.
          state_n     = S_DOWN;
          cnt_n       = '0;
          rep_phase_n = 1'b0;
        end else if (cnt == DB_LAST) begin
          state_n    = S_UP;
          cnt_n      = '0;
          level_n    = 1'b0;
          released_n = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = S_UP;
        cnt_n   = '0;
      end
    endcase
  end

  assign key.o_level       = level;
  assign key.o_pressed     = pressed;
  assign key.o_released    = released;
  assign key.o_press_count = press_count;
  assign key.o_state       = state;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Testbench for key_debounce_pulse (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3). Drivers push expected pulses {kind, level, count,
// cycle} into exp_q; a negedge monitor pops one entry per observed pulse.
module tb_key_debounce_pulse;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = DB + 3;  // drive-to-pulse edges for a stable edge

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_debounce_pulse_if kif ();

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (32)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .key     (kif)
  );

  // ---------------- scoreboard ----------------
  logic [41:0] exp_q[$];
  logic [7:0]  exp_cnt = 8'd0;
  int n_checks = 0;
  int n_pass   = 0;
  int n_press_seen = 0;
  int n_rel_seen   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push(input bit kind, input logic [7:0] cnt, input int at);
    exp_q.push_back({kind, kind, cnt, at[31:0]});
  endtask

  // Monitor: every pulse the DUT presents must match the head of exp_q.
  always @(negedge clk) begin
    logic [41:0] act;
    logic [41:0] e;
    if (rst_n && (kif.o_pressed || kif.o_released)) begin
      act = {kif.o_pressed, kif.o_level, kif.o_press_count, cyc[31:0]};
      if (kif.o_pressed)  n_press_seen++;
      if (kif.o_released) n_rel_seen++;
      check("pulse_exclusive", {63'd0, kif.o_pressed & kif.o_released}, 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got kind/level/count/cycle %0h required no pulse", act);
      end else begin
        e = exp_q.pop_front();
        check("pulse", {22'd0, act}, {22'd0, e});
      end
    end
  end

  // ---------------- drivers ----------------
  // Entered and left at #1 after a posedge.
  task automatic hold(input bit v, input int n);
    kif.i_key_n = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Low for n_low cycles then high for n_high; expectations derived from
  // the acceptance rule (stable for DB+1 drive cycles is enough).
  task automatic key_press(input int n_low, input int n_high);
    int t0;
    int e;
    t0 = cyc;
    if (n_low >= DB + 1) begin
      exp_cnt++;
      push(1'b1, exp_cnt, t0 + LAT);
`ifdef KEY_AUTOREPEAT_EN
      e = t0 + LAT + RD;
      while (e <= t0 + n_low + 2) begin
        exp_cnt++;
        push(1'b1, exp_cnt, e);
        e += RP;
      end
`else
      e = 0;
`endif
      if (n_high >= DB + 1) push(1'b0, exp_cnt, t0 + n_low + LAT);
    end
    hold(1'b0, n_low);
    hold(1'b1, n_high);
  endtask

  task automatic drain(input string name);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      @(posedge clk);
      b++;
    end
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL %s_drain: got %0d pending pulses required 0", name, exp_q.size());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_cnt = 8'd0;
    rst_n   = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    kif.i_key_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level",    {63'd0, kif.o_level},    64'd0);
    check("rst_pressed",  {63'd0, kif.o_pressed},  64'd0);
    check("rst_released", {63'd0, kif.o_released}, 64'd0);
    check("rst_count",    {56'd0, kif.o_press_count}, 64'd0);
    check("rst_state",    {62'd0, kif.o_state},    64'd0);
    rst_n = 1'b1;

    // idle 50 cycles
    hold(1'b1, 50);
    check("idle_level", {63'd0, kif.o_level}, 64'd0);
    check("idle_count", {56'd0, kif.o_press_count}, 64'd0);

    // bounce: low 3 / high 2 repeated, then settle high
    repeat (4) begin
      hold(1'b0, 3);
      hold(1'b1, 2);
    end
    hold(1'b1, 10);
    check("bounce_level", {63'd0, kif.o_level}, 64'd0);
    check("bounce_count", {56'd0, kif.o_press_count}, 64'd0);

    // boundary: low 4 drive cycles is one short, low 5 is accepted
    key_press(4, 10);
    check("short_count", {56'd0, kif.o_press_count}, 64'd0);
    key_press(5, 10);
    drain("min_press");
    check("min_count", {56'd0, kif.o_press_count}, 64'd1);

    // clean presses, level checked while held
    t0 = cyc;
    exp_cnt++;
    push(1'b1, exp_cnt, t0 + LAT);
    hold(1'b0, 9);
    check("held_level", {63'd0, kif.o_level}, 64'd1);
    t0 = cyc;
    push(1'b0, exp_cnt, t0 + LAT);
    hold(1'b1, 9);
    check("released_level", {63'd0, kif.o_level}, 64'd0);
    key_press(8, 8);

    // release bounce: high 4 while held is rejected
    t0 = cyc;
    exp_cnt++;
    push(1'b1, exp_cnt, t0 + LAT);
    hold(1'b0, 8);
    hold(1'b1, 4);
    hold(1'b0, 6);
    check("rel_bounce_level", {63'd0, kif.o_level}, 64'd1);
    t0 = cyc;
    push(1'b0, exp_cnt, t0 + LAT);
    hold(1'b1, 10);

    // long hold: 40 cycles after acceptance
    key_press(47, 10);
    drain("hold");
    check("hold_count", {56'd0, kif.o_press_count}, {56'd0, exp_cnt});
    check("hold_level", {63'd0, kif.o_level}, 64'd0);

    // 256 press/release pairs from reset: counter wraps to 0
    do_reset();
    n_press_seen = 0;
    n_rel_seen   = 0;
    repeat (256) key_press(8, 8);
    drain("wrap");
    check("wrap_count",    {56'd0, kif.o_press_count}, 64'd0);
    check("wrap_presses",  64'(n_press_seen), 64'd256);
    check("wrap_releases", 64'(n_rel_seen),   64'd256);

    // reset while held, then release reset with key still low
    t0 = cyc;
    exp_cnt++;
    push(1'b1, exp_cnt, t0 + LAT);
    hold(1'b0, 10);
    drain("pre_reset");
    rst_n = 1'b0;
    #1;
    check("midrst_level", {63'd0, kif.o_level}, 64'd0);
    check("midrst_count", {56'd0, kif.o_press_count}, 64'd0);
    check("midrst_state", {62'd0, kif.o_state}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    exp_cnt = 8'd0;
    t0 = cyc;
    exp_cnt++;
    push(1'b1, exp_cnt, t0 + LAT);
    rst_n = 1'b1;
    hold(1'b0, 9);
    drain("post_reset");
    check("post_reset_count", {56'd0, kif.o_press_count}, 64'd1);
    check("post_reset_level", {63'd0, kif.o_level}, 64'd1);
    t0 = cyc;
    push(1'b0, exp_cnt, t0 + LAT);
    hold(1'b1, 12);
    drain("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/key_debounce_pulse.md
Name: key_debounce_pulse

Overview:
- Conditions one raw active-low DE2-115 pushbutton (KEY[n]) into clean, clock-synchronous signals.
- Outputs: a debounced level, a single-cycle press pulse, a single-cycle release pulse, and a press counter.
- Sits between the board key pins and the consumers of a one-cycle start/trigger input, such as the random-number generator's i_start.
- Guarantees exactly one o_pressed pulse per physical press; bounce and glitches are rejected.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles the synchronized key must stay stable before a level change is accepted (20 ms at 50 MHz); minimum 2.
- REPEAT_DELAY, 25000000, cycles of continuous hold before the first auto-repeat pulse (only used with the optional feature).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (only used with the optional feature).
- CNT_W, 32, width of the internal timing counter; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- i_clk  input  1  system clock (50 MHz)
- i_rst_n  input  1  asynchronous active-low reset
- i_key_n  input  1  raw pushbutton, asynchronous to i_clk, 0 = pressed
- o_level  output  1  debounced key state, 1 = held
- o_pressed  output  1  one-cycle pulse on an accepted press (and on repeats if enabled)
- o_released  output  1  one-cycle pulse on an accepted release
- o_press_count  output  8  number of o_pressed pulses since reset, wraps 255 -> 0

Behaviour:
- Reset (async, i_rst_n=0):
  - Synchronizer flops = 1 (released); state = S_UP; timing counter = 0.
  - o_level = 0, o_pressed = 0, o_released = 0, o_press_count = 0.
- Synchronizer: two flops on i_key_n, no logic between them. The FSM uses only the second flop's output, key_s.
- State S_UP:
  - key_s=0 -> S_UP_CHK with counter cleared to 0.
  - Otherwise stay.
- State S_UP_CHK:
  - key_s=1 -> S_UP; no pulse; counter cleared.
  - key_s=0 and counter == DEBOUNCE_CYCLES-1 -> S_DOWN; o_level <= 1; o_pressed <= 1 for one cycle; o_press_count <= o_press_count+1.
  - Otherwise counter +1.
- State S_DOWN:
  - key_s=1 -> S_DOWN_CHK with counter cleared.
  - Otherwise stay; the counter is used only by auto-repeat.
- State S_DOWN_CHK:
  - key_s=0 -> S_DOWN, with the counter restarted from 0 (repeat timing restarts).
  - key_s=1 and counter == DEBOUNCE_CYCLES-1 -> S_UP; o_level <= 0; o_released <= 1 for one cycle.
  - Otherwise counter +1.
- Latency: when a raw edge is held stable, the o_pressed / o_released pulse is high in the cycle following clock edge DEBOUNCE_CYCLES+3, counted from the first edge that samples the new value.
- Glitch rejection: any return of key_s to the previous level before the count completes yields no pulse and no o_level change. Bounce therefore restarts the debounce window.
- Outputs are registered; o_pressed and o_released are never high in the same cycle, and never high for two consecutive cycles.
- Counter saturation: the timing counter never wraps. It is cleared on every state entry.
- Press counter: 8-bit modular increment, 255 + 1 = 0, no flag.
- Key held through reset release: treated as a new press. One o_pressed pulse fires DEBOUNCE_CYCLES+3 edges after i_rst_n deasserts.
- Reset asserted mid-debounce or mid-hold: immediate return to reset values. No pulse is emitted on the way out.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - In S_DOWN the counter increments each cycle.
  - At REPEAT_DELAY-1 the block emits an o_pressed pulse (o_press_count increments) and clears the counter.
  - Thereafter it pulses every REPEAT_PERIOD cycles while the key stays held.
  - A release (entry to S_DOWN_CHK) stops repeats.
  - A bounce back into S_DOWN restarts the REPEAT_DELAY wait, not the period.
- Not defined: exactly one o_pressed per press regardless of hold time; REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset release, i_key_n=1 for 50 cycles -> o_level=0, no pulses, o_press_count=0.
- i_key_n falls and stays 0 -> o_pressed high for exactly one cycle, 7 edges after the first sampling edge; o_level=1; o_press_count=1. Release stable -> one o_released pulse 7 edges later, o_level=0.
- Bounce: i_key_n low 3 cycles, high 2, low 3, high (repeated 4 times) -> no o_pressed, o_level stays 0, o_press_count stays 0.
- 256 clean press/release pairs -> o_press_count wraps to 0, with exactly 256 o_pressed and 256 o_released pulses.
- Assert i_rst_n=0 while the key is held in S_DOWN -> all outputs 0 immediately. Release reset with the key still low -> one o_pressed 7 edges later.
- With KEY_AUTOREPEAT_EN, hold the key 40 cycles after acceptance -> extra o_pressed pulses at 10, 13, 16, ... cycles after the first. Without the macro -> only the initial pulse.
